// File: rtl/atm_pin_auth.sv
// PIN authentication stage: latches the account on session start, checks PIN
// entries against a per-account table, enforces retries/lockout/timeout and PIN changes.
module atm_pin_auth #(
  parameter int NUM_ACCOUNTS   = 4,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] account_id_i,
  input  logic [3:0] pin_in_i,
  input  logic       pin_valid_i,
  input  logic       exit_i,
  input  logic       change_req_i,
  input  logic [3:0] new_pin_i,
  output logic       busy_o,
  output logic       auth_ok_o,
  output logic       auth_fail_o,
  output logic       timeout_o,
  output logic       locked_o,
  output logic [1:0] attempts_left_o,
  output logic       pin_changed_o
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK_ACCT,
    WAIT_PIN,
    COMPARE,
    AUTHED,
    FAIL,
    LOCKED
  } StateT;

  StateT                   state_q, state_d;
  logic [3:0]              acctId_q, acctId_d;
  logic [3:0]              pinIn_q, pinIn_d;
  logic [7:0]              timer_q, timer_d;
  logic [1:0]              attempts_q, attempts_d;
  logic [3:0]              pinTable_q [NUM_ACCOUNTS];
  logic [3:0]              pinTable_d [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock_q, lock_d;
  logic [3:0]              storedPin;
  logic                    acctLocked;
  logic                    acctValid;
  logic                    timeoutHit;
  logic                    pinWrite;

  // Table lookups go through a loop so an out-of-range ID never indexes past the arrays.
  always_comb begin
    storedPin  = '0;
    acctLocked = 1'b0;
    for (int i = 0; i < NUM_ACCOUNTS; i++) begin
      if (acctId_q == 4'(i)) begin
        storedPin  = pinTable_q[i];
        acctLocked = lock_q[i];
      end
    end
    acctValid = 32'(acctId_q) < NUM_ACCOUNTS;
  end

  always_comb begin
    state_d    = state_q;
    acctId_d   = acctId_q;
    pinIn_d    = pinIn_q;
    timer_d    = timer_q;
    attempts_d = attempts_q;
    pinTable_d = pinTable_q;
    lock_d     = lock_q;
    timeoutHit = 1'b0;
    pinWrite   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = CHECK_ACCT;
          acctId_d = account_id_i;
        end
      end
      CHECK_ACCT: begin
        if (!acctValid) begin
          state_d = FAIL;
        end else if (acctLocked) begin
          state_d = LOCKED;
        end else begin
          state_d    = WAIT_PIN;
          attempts_d = 2'(MAX_TRIES);
          timer_d    = '0;
        end
      end
      WAIT_PIN: begin
        timer_d = timer_q + 8'd1;
        if (exit_i) begin
          state_d = IDLE;
        end else if (pin_valid_i) begin
          state_d = COMPARE;
          pinIn_d = pin_in_i;
        end else if (timer_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d    = FAIL;
          timeoutHit = 1'b1;
        end
      end
      COMPARE: begin
        if (pinIn_q == storedPin) begin
          state_d = AUTHED;
        end else begin
          attempts_d = attempts_q - 2'd1;
          if (attempts_q == 2'd1) begin
            state_d = LOCKED;
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
              if (acctId_q == 4'(i)) lock_d[i] = 1'b1;
            end
          end else begin
            state_d = WAIT_PIN;
            timer_d = '0;
          end
        end
      end
      AUTHED: begin
        if (exit_i) begin
          state_d = IDLE;
        end else if (change_req_i) begin
          pinWrite = 1'b1;
          for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            if (acctId_q == 4'(i)) pinTable_d[i] = new_pin_i;
          end
        end
      end
      FAIL: begin
        state_d = IDLE;
      end
      LOCKED: begin
        if (exit_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q         <= IDLE;
      acctId_q        <= '0;
      pinIn_q         <= '0;
      timer_q         <= '0;
      attempts_q      <= '0;
      lock_q          <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) pinTable_q[i] <= 4'(i);
      busy_o          <= 1'b0;
      auth_ok_o       <= 1'b0;
      auth_fail_o     <= 1'b0;
      timeout_o       <= 1'b0;
      locked_o        <= 1'b0;
      attempts_left_o <= '0;
      pin_changed_o   <= 1'b0;
    end else begin
      state_q         <= state_d;
      acctId_q        <= acctId_d;
      pinIn_q         <= pinIn_d;
      timer_q         <= timer_d;
      attempts_q      <= attempts_d;
      lock_q          <= lock_d;
      pinTable_q      <= pinTable_d;
      busy_o          <= (state_d != IDLE);
      auth_ok_o       <= (state_d == AUTHED);
      auth_fail_o     <= (state_d == FAIL);
      timeout_o       <= timeoutHit;
      locked_o        <= (state_d == LOCKED);
      attempts_left_o <= attempts_d;
      pin_changed_o   <= pinWrite;
    end
  end

endmodule
